// File: rtl/axis_rx_checker.sv
// Receive-side AXI-Stream sink: counts packets per source and in total, and checks
// destination, source index, sequence number and injection tick. Optional stats: AXIS_CHECKER_LATENCY_STATS_EN.

module axis_rx_src_cnt #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
endmodule

module axis_rx_checker #(
    parameter int COUNT_WIDTH = 32,
    parameter int TDEST       = 0,
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int NUM_ROUTERS = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [TDATA_WIDTH/2-1:0]                 ticks,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0]  recv_packets,
    output logic [COUNT_WIDTH-1:0]                   total_recv_packets,
    output logic                                     error,
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
    output logic [COUNT_WIDTH+15:0]                  latency_sum,
    output logic [TDATA_WIDTH/2-1:0]                 latency_max,
`endif
    input  logic                                     axis_in_tvalid,
    output logic                                     axis_in_tready,
    input  logic [TDATA_WIDTH-1:0]                   axis_in_tdata,
    input  logic                                     axis_in_tlast,
    input  logic [TID_WIDTH-1:0]                     axis_in_tid,
    input  logic [TDEST_WIDTH-1:0]                   axis_in_tdest
);
    localparam int HW    = TDATA_WIDTH / 2;
    localparam int CMP_W = (COUNT_WIDTH < HW) ? COUNT_WIDTH : HW;

    typedef struct packed {
        logic [HW-1:0] inj;
        logic [HW-1:0] seq;
    } payload_t;

    payload_t             pl;
    logic                 in_packet;
    logic                 beat, first, last_beat, fail;
    logic [TID_WIDTH-1:0] tid_lat, tid_eff;
    logic                 tid_ok, tid_ok_lat, tid_ok_eff;
    logic [31:0]          tid_ext;
    logic [COUNT_WIDTH-1:0] cnt_sel;
    logic [NUM_ROUTERS-1:0] inc;

    assign pl        = axis_in_tdata;
    assign beat      = axis_in_tvalid & axis_in_tready;
    assign first     = beat & ~in_packet;
    assign last_beat = beat & axis_in_tlast;
    assign tid_ext   = 32'(axis_in_tid);
    assign tid_ok    = tid_ext < 32'(NUM_ROUTERS);

    // Counting uses the source seen at the first beat; single-beat packets use it directly.
    assign tid_eff    = in_packet ? tid_lat    : axis_in_tid;
    assign tid_ok_eff = in_packet ? tid_ok_lat : tid_ok;

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_ROUTERS; i++)
            if (axis_in_tid == TID_WIDTH'(i)) cnt_sel = recv_packets[i];
    end

    assign fail = (axis_in_tdest != TDEST_WIDTH'(TDEST))
                | ~tid_ok
                | (pl.seq[CMP_W-1:0] != cnt_sel[CMP_W-1:0])
                | (pl.inj > ticks);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_in_tready     <= 1'b0;
            in_packet          <= 1'b0;
            tid_lat            <= '0;
            tid_ok_lat         <= 1'b0;
            error              <= 1'b0;
            total_recv_packets <= '0;
        end else begin
            axis_in_tready <= 1'b1;
            if (beat) in_packet <= ~axis_in_tlast;
            if (first) begin
                tid_lat    <= axis_in_tid;
                tid_ok_lat <= tid_ok;
                if (fail) error <= 1'b1;
            end
            if (last_beat) total_recv_packets <= total_recv_packets + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_ROUTERS; g++) begin : g_src
            assign inc[g] = last_beat & tid_ok_eff & (tid_eff == TID_WIDTH'(g));
            axis_rx_src_cnt #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc[g]),
                .cnt   (recv_packets[g])
            );
        end
    endgenerate

`ifdef AXIS_CHECKER_LATENCY_STATS_EN
    logic [HW-1:0] lat_now, lat_lat, lat_eff;

    assign lat_now = ticks - pl.inj;
    assign lat_eff = in_packet ? lat_lat : lat_now;

    // Latency is sampled at the first beat but committed with the packet count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_lat     <= '0;
            latency_sum <= '0;
            latency_max <= '0;
        end else begin
            if (first) lat_lat <= lat_now;
            if (last_beat) begin
                latency_sum <= latency_sum + (COUNT_WIDTH+16)'(lat_eff);
                if (lat_eff > latency_max) latency_max <= lat_eff;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_rx_checker.sv
// Scoreboard bench for axis_rx_checker: directed beats push hand-computed
// expected state; a negedge monitor pops and compares.

module tb_axis_rx_checker;
    logic               clk = 0;
    logic               rst_n = 0;
    logic [31:0]        ticks = 0;
    logic [3:0][31:0]   recv_packets;
    logic [31:0]        total_recv_packets;
    logic               error;
    logic               tvalid = 0, tready, tlast = 0;
    logic [63:0]        tdata = 0;
    logic [1:0]         tid = 0, tdest = 0;
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
    logic [47:0]        latency_sum;
    logic [31:0]        latency_max;
`endif

    axis_rx_checker dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ticks              (ticks),
        .recv_packets       (recv_packets),
        .total_recv_packets (total_recv_packets),
        .error              (error),
`ifdef AXIS_CHECKER_LATENCY_STATS_EN
        .latency_sum        (latency_sum),
        .latency_max        (latency_max),
`endif
        .axis_in_tvalid     (tvalid),
        .axis_in_tready     (tready),
        .axis_in_tdata      (tdata),
        .axis_in_tlast      (tlast),
        .axis_in_tid        (tid),
        .axis_in_tdest      (tdest)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        string            name;
        logic [31:0]      tot;
        logic [3:0][31:0] r;
        logic             err;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, ".tot"}, total_recv_packets, e.tot);
            for (int i = 0; i < 4; i++)
                chk($sformatf("%s.r%0d", e.name, i), recv_packets[i], e.r[i]);
            chk({e.name, ".err"}, {31'b0, error}, {31'b0, e.err});
            chk({e.name, ".rdy"}, {31'b0, tready}, 32'd1);
        end
    end

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic beat(input string name, input logic v, input logic l, input logic [1:0] id,
                        input logic [1:0] dst, input logic [31:0] inj, input logic [31:0] sq,
                        input logic [31:0] tk, input logic [31:0] et,
                        input logic [3:0][31:0] er, input logic ee);
        exp_t e;
        @(posedge clk); #1;
        tvalid = v; tlast = l; tid = id; tdest = dst; tdata = {inj, sq}; ticks = tk;
        e.cyc = cyc + 1; e.name = name; e.tot = et; e.r = er; e.err = ee;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin @(posedge clk); n++; end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic do_reset(input string name);
        drain();
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk({name, ".rst_tot"}, total_recv_packets, 0);
        chk({name, ".rst_r"}, {recv_packets[0] | recv_packets[1] | recv_packets[2] | recv_packets[3]}, 0);
        chk({name, ".rst_err"}, {31'b0, error}, 0);
        chk({name, ".rst_rdy"}, {31'b0, tready}, 0);
        tvalid = 0; tlast = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        chk({name, ".rdy_up"}, {31'b0, tready}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset + idle
        do_reset("init");
        beat("idle",  0, 0, 0, 0,  0, 0, 10, 0, {32'd0, 32'd0, 32'd0, 32'd0}, 0);
        beat("p1",    1, 1, 1, 0,  5, 0, 10, 1, {32'd0, 32'd0, 32'd1, 32'd0}, 0);
        beat("seqbad",1, 1, 1, 0,  5, 0, 10, 2, {32'd0, 32'd0, 32'd2, 32'd0}, 1);
        beat("sticky",1, 1, 0, 0,  5, 0, 10, 3, {32'd0, 32'd0, 32'd2, 32'd1}, 1);
        beat("idle2", 0, 0, 0, 0,  0, 0, 10, 3, {32'd0, 32'd0, 32'd2, 32'd1}, 1);

        // wrong destination
        do_reset("rstB");
        beat("dest",  1, 1, 2, 2,  5, 0, 10, 1, {32'd0, 32'd1, 32'd0, 32'd0}, 1);
        beat("idleB", 0, 0, 0, 0,  0, 0, 10, 1, {32'd0, 32'd1, 32'd0, 32'd0}, 1);

        // multi-beat packet, mid-beat garbage unchecked; then future tick
        do_reset("rstC");
        beat("mb1",   1, 0, 3, 0,  5,  0, 10, 0, {32'd0, 32'd0, 32'd0, 32'd0}, 0);
        beat("mb2",   1, 0, 1, 3, 99, 77, 10, 0, {32'd0, 32'd0, 32'd0, 32'd0}, 0);
        beat("mb3",   1, 1, 0, 1, 99, 55, 10, 1, {32'd1, 32'd0, 32'd0, 32'd0}, 0);
        beat("t3s1",  1, 1, 3, 0,  5,  1, 10, 2, {32'd2, 32'd0, 32'd0, 32'd0}, 0);
        beat("future",1, 1, 0, 0, 11,  0, 10, 3, {32'd2, 32'd0, 32'd0, 32'd1}, 1);
        beat("idleC", 0, 0, 0, 0,  0,  0, 10, 3, {32'd2, 32'd0, 32'd0, 32'd1}, 1);

        // five good packets (tick == ticks boundary), then reset mid-packet
        do_reset("rstD");
        beat("d1",    1, 1, 0, 0, 10, 0, 10, 1, {32'd0, 32'd0, 32'd0, 32'd1}, 0);
        beat("d2",    1, 1, 0, 0,  3, 1, 10, 2, {32'd0, 32'd0, 32'd0, 32'd2}, 0);
        beat("d3",    1, 1, 1, 0,  3, 0, 10, 3, {32'd0, 32'd0, 32'd1, 32'd2}, 0);
        beat("d4",    1, 1, 2, 0,  3, 0, 10, 4, {32'd0, 32'd1, 32'd1, 32'd2}, 0);
        beat("nvld",  0, 1, 2, 0,  3, 0, 10, 4, {32'd0, 32'd1, 32'd1, 32'd2}, 0);
        beat("d5",    1, 1, 0, 0,  3, 2, 10, 5, {32'd0, 32'd1, 32'd1, 32'd3}, 0);
        beat("part",  1, 0, 1, 0,  3, 1, 10, 5, {32'd0, 32'd1, 32'd1, 32'd3}, 0);
        do_reset("rstE");
        beat("e1",    1, 1, 1, 0,  3, 0, 10, 1, {32'd0, 32'd0, 32'd1, 32'd0}, 0);
        beat("e2",    1, 1, 1, 0,  3, 1, 10, 2, {32'd0, 32'd0, 32'd2, 32'd0}, 0);
        beat("idleE", 0, 0, 0, 0,  0, 0, 10, 2, {32'd0, 32'd0, 32'd2, 32'd0}, 0);
        drain();
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_rx_checker.md
Name: axis_rx_checker

Overview:
- Receive-side sink for one NoC endpoint in the mesh test harness; instantiated once per router output port.
- Accepts AXI-Stream packets from the network and counts them per source (tid) and in total.
- Checks each packet for correct destination, valid source, in-order sequence number and a sane injection timestamp.
- Raises a sticky error flag on any violation.

Parameters:
- COUNT_WIDTH, 32, width of every packet counter.
- TDEST, 0, this endpoint's own destination index; every packet must carry it.
- TDATA_WIDTH, 64, stream data width; must be even.
- TDEST_WIDTH, 2, width of tdest.
- TID_WIDTH, 2, width of tid (source index).
- NUM_ROUTERS, 4, number of possible sources; must be ≤ 2^TID_WIDTH.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- ticks  in  TDATA_WIDTH/2  free-running global cycle counter.
- recv_packets  out  [NUM_ROUTERS] x COUNT_WIDTH  per-source packet counts.
- total_recv_packets  out  COUNT_WIDTH  total packets received.
- error  out  1  sticky error flag.
- axis_in_tvalid  in  1  stream valid.
- axis_in_tready  out  1  stream ready.
- axis_in_tdata  in  TDATA_WIDTH  payload: [TDATA_WIDTH-1:TDATA_WIDTH/2] = injection tick, [TDATA_WIDTH/2-1:0] = per-source sequence number.
- axis_in_tlast  in  1  end of packet.
- axis_in_tid  in  TID_WIDTH  source index.
- axis_in_tdest  in  TDEST_WIDTH  destination index.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - all recv_packets, total_recv_packets = 0; error = 0; axis_in_tready = 0.
- axis_in_tready is a register:
  - becomes 1 on the first clk edge after rst_n deasserts;
  - stays 1 until the next reset; the block never back-pressures.
- Beat accepted when tvalid && tready. A packet may span several beats; the packet ends on the accepted beat with tlast=1.
- Checks are performed on the first beat of each packet; tracked with a 1-bit in_packet register, set after a non-tlast beat and cleared after a tlast beat.
- First-beat checks (any failure sets error at the next edge):
  - tdest != TDEST;
  - tid ≥ NUM_ROUTERS;
  - sequence field != recv_packets[tid], compared over the low min(COUNT_WIDTH, TDATA_WIDTH/2) bits;
  - injection tick > ticks (unsigned).
- error is sticky; only reset clears it.
- Counting happens on the accepted tlast beat:
  - total_recv_packets +1;
  - recv_packets[tid] +1 if the tid latched at the first beat is < NUM_ROUTERS; otherwise no per-source update.
- Counts update one cycle after the beat; counters wrap modulo 2^COUNT_WIDTH.
- A single-beat packet (tlast=1 on the first beat) is checked and counted in the same cycle.
- The per-source count increments even when the sequence check fails (expected value = count, not last seen + 1).
- Reset mid-packet: counters, error and in_packet all return to 0; the partial packet is discarded.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro AXIS_CHECKER_LATENCY_STATS_EN.
- When defined, adds two outputs:
  - latency_sum, COUNT_WIDTH+16 bits: accumulates ticks − injection tick at each packet's first beat;
  - latency_max, TDATA_WIDTH/2 bits: the maximum of those values.
- Both outputs reset to 0 and update on the same edge as the counts.
- When not defined, these ports and their registers are absent and all other behaviour is identical.

Test Plan:
- Reset, then idle: tready=1 one cycle after rst_n rises; all counts 0; error 0.
- TDEST=0, single-beat packet tid=1, seq=0, tick=5, ticks=10 → recv_packets[1]=1, total=1, error=0.
- Second packet from tid=1 with seq=0 (expected 1) → error=1 next cycle, recv_packets[1]=2, and error stays 1 through further valid traffic.
- Packet with tdest=2 at a TDEST=0 checker → error=1; total increments.
- 3-beat packet tid=3, seq=0, tlast on the 3rd beat → total increments only after beat 3; mid-beat data is not checked.
- Assert rst_n=0 mid-packet after 5 packets counted → counts and error clear immediately; a new packet with seq=0 passes.
